mem_access_sequencer: RTL
=========================

// Module: mem_access_sequencer
// PURPOSE
//  Multi-cycle load/store sequencer between the single-cycle RV32 core and a handshaked data bus.
//  Takes the decoded MemWrite/Load/Store controls and the ALU-computed address, and runs one bus transaction.
//  Asserts stall to freeze PC/regfile until the access completes, then returns sign/zero-extended load data.
//  Rejects misaligned accesses and aborts on bus timeout.
// PARAMETERS
//  TO_CYCLES  255  max BUS-state cycles waiting for bus_ack before abort (1..2^TO_W-1)
//  TO_W       8    width of timeout counter
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  mem_rd     in   1   load instruction (ResultSrc==01)
//  MemWrite   in   1   store instruction
//  Store      in   2   00 sw, 01 sh, 10 sb (11 treated as sw)
//  Load       in   3   funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (others as lw)
//  addr       in   32  byte address from ALU
//  wdata      in   32  store data (rs2)
//  stall      out  1   hold PC and suppress RegWrite
//  rdata      out  32  extended load result, valid while done=1
//  done       out  1   one-cycle completion strobe
//  misalign   out  1   one-cycle strobe: access rejected, no bus cycle
//  timeout    out  1   one-cycle strobe: bus did not ack in TO_CYCLES
//  bus_req    out  1   transaction request, held until ack
//  bus_we     out  1   1 = write
//  bus_addr   out  32  word address {addr[31:2],2'b00}
//  bus_wdata  out  32  lane-replicated store data
//  bus_be     out  4   byte enables (all 1 for reads)
//  bus_rdata  in   32  read data, sampled when bus_ack=1
//  bus_ack    in   1   transaction complete
// BEHAVIOUR
//  Reset (async): state=IDLE, counter=0. Registered outputs go 0: bus_req, bus_we, bus_addr, bus_wdata, bus_be, rdata,
//   done, misalign, timeout. stall has no reset value of its own: it is a combinational decode and reads 0 in reset.
//  Request valid = mem_rd|MemWrite. If both are 1, MemWrite wins (write).
//  Alignment: word needs addr[1:0]==0; half needs addr[0]==0; byte is always aligned.
//  IDLE
//   - Valid aligned request: latch addr/wdata/size/type and go to BUS.
//     stall=1 combinationally in this same cycle.
//   - Misaligned request: misalign=1 for the next cycle, stay in IDLE, stall=0, no bus_req.
//  BUS
//   - bus_req=1, stall=1. bus_we/addr/wdata/be are registered and stay stable until ack.
//   - bus_ack=1: capture the extended bus_rdata (writes: rdata=0), counter=0, go to DONE.
//   - No ack: counter+1. When counter==TO_CYCLES-1 without ack: timeout, rdata=0, go to DONE.
//  DONE
//   - done=1, stall=0, bus_req=0. The core commits in this cycle and the PC advances at its end.
//   - Always returns to IDLE. The same request still visible on the inputs here is not re-issued.
//  Byte enables:
//   - sb: be=1<<addr[1:0], wdata={4{wdata[7:0]}}
//   - sh: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}
//   - sw: be=1111
//  Load extract:
//   - byte = word >> (8*addr[1:0]); half = word >> (16*addr[1]).
//   - lb/lh sign-extend; lbu/lhu zero-extend.
//  Latency: zero-wait ack gives 3 cycles IDLE->BUS->DONE; each ack wait state adds 1.
//  Reset mid-BUS: bus_req drops immediately and the transaction is abandoned. No done strobe.
// TESTING
//  lw addr=0x100, ack after 2 wait cycles, bus_rdata=0xDEADBEEF
//   -> bus_addr=0x100, be=1111, stall 4 cycles, done with rdata=0xDEADBEEF
//  sb addr=0x203, wdata=0x000000A5, ack immediately
//   -> bus_addr=0x200, be=1000, bus_wdata=0xA5A5A5A5, bus_we=1, done after 3 cycles
//  lh addr=0x302, bus_rdata=0x8001_1234 -> rdata=0xFFFF8001
//  lhu addr=0x302, same data -> rdata=0x00008001
//  lw addr=0x101 -> misalign=1 next cycle, bus_req never rises, stall=0
//  lw with ack never returned, TO_CYCLES=4 -> timeout and done in same cycle, rdata=0, back to IDLE
//  reset asserted in 2nd BUS cycle -> bus_req=0 asynchronously; a new lw after reset completes normally
//  mem_rd=1 and MemWrite=1 together, sw addr=0x40 -> bus_we=1, be=1111

Source files
------------

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Multi-cycle load/store sequencer sitting between a single-cycle RV32 core
//   and a request/acknowledge data bus. One load or store runs as one bus
//   transaction. stall freezes the core until the access completes, and load
//   data comes back sign- or zero-extended. Misaligned accesses are rejected
//   without touching the bus. An access that is not acknowledged within
//   TO_CYCLES bus cycles is aborted.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   mem_rd, MemWrite      load / store request (MemWrite wins if both are set)
//   Store[1:0]            00 sw, 01 sh, 10 sb, 11 sw
//   Load[2:0]             000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu, others lw
//   addr, wdata           byte address and store data from the core
//   stall                 holds the PC and suppresses register write-back
//   rdata, done           extended load result, valid with the done strobe
//   misalign, timeout     one-cycle error strobes
//   bus_req/we/addr/wdata/be   registered bus request, held until bus_ack
//   bus_rdata, bus_ack    bus response
module mem_access_sequencer #(
  parameter int unsigned TO_W      = 8,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        MemWrite,
  input  logic [1:0]  Store,
  input  logic [2:0]  Load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last BUS-state count value before the access is abandoned.
  localparam logic [TO_W-1:0] TO_LAST_C = TO_W'(TO_CYCLES - 1);

  state_t            state_r, state_next_s;
  logic [TO_W-1:0]   cnt_r;
  logic [1:0]        addr_lo_r;
  logic [2:0]        load_r;
  logic              bus_req_r, bus_we_r, done_r, misalign_r, timeout_r;
  logic [31:0]       bus_addr_r, bus_wdata_r, rdata_r;
  logic [3:0]        bus_be_r;

  logic              req_s, aligned_s, issue_s, reject_s, stall_s;
  logic [1:0]        size_s;    // 00 byte, 01 half, 10 word
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;

  // Pick the requested word lane out of the bus word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [2:0]  ld);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = word >> {lo, 3'b000};
    sh_h = word >> {lo[1], 4'b0000};
    case (ld)
      3'b000:  load_extract = {{24{sh_b[7]}}, sh_b[7:0]};
      3'b001:  load_extract = {{16{sh_h[15]}}, sh_h[15:0]};
      3'b100:  load_extract = {24'd0, sh_b[7:0]};
      3'b101:  load_extract = {16'd0, sh_h[15:0]};
      default: load_extract = word;
    endcase
  endfunction

  // Decode access size, alignment and store lane formatting from the core inputs.
  always_comb begin
    req_s   = mem_rd | MemWrite;
    size_s  = 2'b10;
    be_s    = 4'b1111;
    wdata_s = wdata;
    if (MemWrite) begin
      case (Store)
        2'b10: begin
          size_s  = 2'b00;
          be_s    = 4'b0001 << addr[1:0];
          wdata_s = {4{wdata[7:0]}};
        end
        2'b01: begin
          size_s  = 2'b01;
          be_s    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_s = {2{wdata[15:0]}};
        end
        default: begin
          size_s  = 2'b10;
          be_s    = 4'b1111;
          wdata_s = wdata;
        end
      endcase
    end else begin
      // Reads always fetch the whole word; the lane is picked on return.
      be_s    = 4'b1111;
      wdata_s = 32'd0;
      case (Load[1:0])
        2'b00:   size_s = 2'b00;
        2'b01:   size_s = 2'b01;
        default: size_s = 2'b10;
      endcase
    end
    case (size_s)
      2'b00:   aligned_s = 1'b1;
      2'b01:   aligned_s = ~addr[0];
      default: aligned_s = (addr[1:0] == 2'b00);
    endcase
    issue_s  = (state_r == ST_IDLE) & req_s & aligned_s;
    reject_s = (state_r == ST_IDLE) & req_s & ~aligned_s;
  end

  // Next-state logic and the combinational stall decode (forced low in reset).
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          state_next_s = ST_BUS;
          stall_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        stall_s = 1'b1;
        if (bus_ack || (cnt_r == TO_LAST_C)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUS;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
    if (reset) begin
      stall_s = 1'b0;
    end else begin
      stall_s = stall_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus request, wait counter, latched access info and result strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= '0;
      addr_lo_r   <= 2'b00;
      load_r      <= 3'b000;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
      bus_be_r    <= 4'b0000;
      rdata_r     <= 32'd0;
      done_r      <= 1'b0;
      misalign_r  <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
      timeout_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            bus_req_r   <= 1'b1;
            bus_we_r    <= MemWrite;
            bus_addr_r  <= {addr[31:2], 2'b00};
            bus_wdata_r <= wdata_s;
            bus_be_r    <= be_s;
            addr_lo_r   <= addr[1:0];
            load_r      <= Load;
            cnt_r       <= '0;
          end else if (reject_s) begin
            misalign_r <= 1'b1;
          end else begin
            cnt_r <= '0;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            bus_req_r <= 1'b0;
            rdata_r   <= bus_we_r ? 32'd0 : load_extract(bus_rdata, addr_lo_r, load_r);
            done_r    <= 1'b1;
            cnt_r     <= '0;
          end else if (cnt_r == TO_LAST_C) begin
            bus_req_r <= 1'b0;
            rdata_r   <= 32'd0;
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
            cnt_r     <= '0;
          end else begin
            cnt_r <= cnt_r + TO_W'(1);
          end
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign stall     = stall_s;
  assign rdata     = rdata_r;
  assign done      = done_r;
  assign misalign  = misalign_r;
  assign timeout   = timeout_r;
  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign bus_be    = bus_be_r;

endmodule
